// File: rtl/mem_stage_sequencer.sv
// MEM-stage sequencer: holds the instruction across cache misses and write-back stalls and
// extracts load data. Define MEM_SEQ_TIMEOUT_EN to enable the sticky WAIT-state timeout.
module mem_stage_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic                      i_flush,
  input  logic                      i_is_mem_access,
  input  logic                      i_mem_action,
  input  logic [1:0]                i_size,
  input  logic                      i_sign_ext,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic                      i_uses_rw,
  input  logic [REG_ADDR_WIDTH-1:0] i_rw_addr,
  input  logic                      i_cache_valid,
  input  logic [DATA_WIDTH-1:0]     i_cache_data,
  input  logic                      i_wb_ready,
  output logic                      o_done,
  output logic                      o_wb_valid,
  output logic                      o_wb_uses_rw,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_rw_addr,
  output logic [DATA_WIDTH-1:0]     o_wb_rw_data,
  output logic                      o_misaligned,
  output logic                      o_timeout
);

  localparam int unsigned LaneW = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e                    state_q, state_d;
  // Holds the address (and store data) while waiting, the final result while holding.
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      uses_q, uses_d;
  logic                      store_q, store_d;
  logic                      sign_q, sign_d;
  logic [1:0]                size_q, size_d;

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] data,
                                                    input logic [LaneW-1:0]      lane,
                                                    input logic [1:0]            size,
                                                    input logic                  sign_ext);
    logic [DATA_WIDTH-1:0] shifted, mask, msb;
    int unsigned           nbits;
    shifted = data >> {lane, 3'b000};
    unique case (size)
      2'b00:   nbits = 8;
      2'b01:   nbits = 16;
      2'b10:   nbits = 32;
      default: nbits = DATA_WIDTH;
    endcase
    mask = ~({DATA_WIDTH{1'b1}} << nbits);
    msb  = mask ^ (mask >> 1);
    extract = shifted & mask;
    if (sign_ext && |(shifted & msb)) extract = extract | ~mask;
  endfunction

  function automatic logic misaligned(input logic [2:0] addr, input logic [1:0] size);
    unique case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = |addr;
    endcase
  endfunction

  logic                  idle_mis, idle_store, idle_uses;
  logic [DATA_WIDTH-1:0] idle_res, wait_res;

  assign idle_mis   = i_is_mem_access & misaligned(i_alu_result[2:0], i_size);
  assign idle_store = i_is_mem_access & i_mem_action;
  assign idle_uses  = i_uses_rw & ~idle_store & ~idle_mis;
  assign idle_res   = (i_is_mem_access & ~idle_mis & ~i_mem_action) ?
                      extract(i_cache_data, i_alu_result[LaneW-1:0], i_size, i_sign_ext) :
                      i_alu_result;
  assign wait_res   = store_q ? data_q : extract(i_cache_data, data_q[LaneW-1:0], size_q, sign_q);

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    rd_d         = rd_q;
    uses_d       = uses_q;
    store_d      = store_q;
    sign_d       = sign_q;
    size_d       = size_q;
    o_done       = 1'b0;
    o_wb_valid   = 1'b0;
    o_wb_uses_rw = 1'b0;
    o_wb_rw_addr = '0;
    o_wb_rw_data = '0;
    o_misaligned = 1'b0;
    if (i_flush) begin
      o_done  = 1'b1;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!i_valid) begin
            o_done = 1'b1;
          end else begin
            o_misaligned = idle_mis;
            rd_d         = i_rw_addr;
            uses_d       = idle_uses;
            if (i_is_mem_access && !idle_mis && !i_cache_valid) begin
              data_d  = i_alu_result;
              store_d = i_mem_action;
              sign_d  = i_sign_ext;
              size_d  = i_size;
              state_d = StWait;
            end else begin
              o_done       = i_wb_ready;
              o_wb_valid   = i_wb_ready;
              o_wb_uses_rw = idle_uses;
              o_wb_rw_addr = i_rw_addr;
              o_wb_rw_data = idle_res;
              data_d       = idle_res;
              if (!i_wb_ready) state_d = StHold;
            end
          end
        end
        StWait: begin
          if (i_cache_valid) begin
            o_done       = i_wb_ready;
            o_wb_valid   = i_wb_ready;
            o_wb_uses_rw = uses_q;
            o_wb_rw_addr = rd_q;
            o_wb_rw_data = wait_res;
            data_d       = wait_res;
            state_d      = i_wb_ready ? StIdle : StHold;
          end
        end
        StHold: begin
          o_done       = i_wb_ready;
          o_wb_valid   = i_wb_ready;
          o_wb_uses_rw = uses_q;
          o_wb_rw_addr = rd_q;
          o_wb_rw_data = data_q;
          if (i_wb_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      rd_q    <= '0;
      uses_q  <= 1'b0;
      store_q <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      uses_q  <= uses_d;
      store_q <= store_d;
      sign_q  <= sign_d;
      size_q  <= size_d;
    end
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, hit;

  // hit marks the WAIT cycle whose ordinal reaches the limit, so the flag shows in that cycle.
  assign hit       = (state_q == StWait) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
  assign cnt_d     = (state_q == StWait && state_d == StWait) ?
                     ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1) : '0;
  assign o_timeout = timeout_q | hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | hit;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed bench for mem_stage_sequencer: a per-cycle reference model of outstanding
// instructions plus literal expectations at the key points of each scenario.
module tb_mem_stage_sequencer;

  localparam int unsigned Tmo = 4;
`ifdef MEM_SEQ_TIMEOUT_EN
  localparam logic ToEn = 1'b1;
`else
  localparam logic ToEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid, i_flush, i_is_mem_access, i_mem_action, i_sign_ext, i_uses_rw;
  logic [1:0]  i_size;
  logic [31:0] i_alu_result, i_cache_data;
  logic [4:0]  i_rw_addr;
  logic        i_cache_valid, i_wb_ready;
  logic        o_done, o_wb_valid, o_wb_uses_rw, o_misaligned, o_timeout;
  logic [4:0]  o_wb_rw_addr;
  logic [31:0] o_wb_rw_data;

  always #5 clk = ~clk;

  mem_stage_sequencer #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .i_flush         (i_flush),
    .i_is_mem_access (i_is_mem_access),
    .i_mem_action    (i_mem_action),
    .i_size          (i_size),
    .i_sign_ext      (i_sign_ext),
    .i_alu_result    (i_alu_result),
    .i_uses_rw       (i_uses_rw),
    .i_rw_addr       (i_rw_addr),
    .i_cache_valid   (i_cache_valid),
    .i_cache_data    (i_cache_data),
    .i_wb_ready      (i_wb_ready),
    .o_done          (o_done),
    .o_wb_valid      (o_wb_valid),
    .o_wb_uses_rw    (o_wb_uses_rw),
    .o_wb_rw_addr    (o_wb_rw_addr),
    .o_wb_rw_data    (o_wb_rw_data),
    .o_misaligned    (o_misaligned),
    .o_timeout       (o_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load value: byte lane arithmetic with explicit two's-complement wrap.
  function automatic logic [31:0] load_val(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sx);
    longint v, span;
    int     sh;
    sh   = 8 * int'(a % 4);
    span = (sz == 2'd0) ? 64'd256 : (sz == 2'd1) ? 64'd65536 : 64'h1_0000_0000;
    v    = longint'(d >> sh) % span;
    if (sx && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic misal(input logic [31:0] a, input logic [1:0] sz);
    int align;
    align = 1 << sz;
    return (a % align) != 0;
  endfunction

  // Model: at most one outstanding instruction; either awaiting data or holding its result.
  logic        m_pend, m_resolved, m_uses, m_store, m_sign, m_to;
  logic [1:0]  m_size;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_waits;
  logic        n_pend, n_resolved, n_uses, n_store, n_sign, n_to;
  logic [1:0]  n_size;
  logic [4:0]  n_rd;
  logic [31:0] n_data;
  int          n_waits;
  logic        e_done, e_valid, e_uses, e_mis, e_to;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0; m_resolved <= 1'b0; m_uses <= 1'b0; m_store <= 1'b0; m_sign <= 1'b0;
      m_to <= 1'b0; m_size <= 2'd0; m_rd <= 5'd0; m_data <= 32'd0; m_waits <= 0;
    end else begin
      m_pend <= n_pend; m_resolved <= n_resolved; m_uses <= n_uses; m_store <= n_store;
      m_sign <= n_sign; m_to <= n_to; m_size <= n_size; m_rd <= n_rd; m_data <= n_data;
      m_waits <= n_waits;
    end
  end

  task automatic present(input logic [31:0] res, input logic uses, input logic [4:0] rd);
    e_done = i_wb_ready; e_valid = i_wb_ready;
    e_data = res; e_uses = uses; e_rd = rd;
    n_pend = !i_wb_ready; n_resolved = 1'b1; n_data = res; n_uses = uses; n_rd = rd;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic waiting, mis, store;
      n_pend = m_pend; n_resolved = m_resolved; n_uses = m_uses; n_store = m_store;
      n_sign = m_sign; n_size = m_size; n_rd = m_rd; n_data = m_data;
      e_done = 1'b0; e_valid = 1'b0; e_uses = 1'b0; e_mis = 1'b0; e_rd = 5'd0; e_data = 32'd0;
      waiting = m_pend && !m_resolved;
      e_to    = m_to || (ToEn && waiting && (m_waits + 1 >= Tmo));
      n_to    = e_to;
      if (i_flush) begin
        e_done = 1'b1; n_pend = 1'b0;
      end else if (!m_pend) begin
        if (!i_valid) begin
          e_done = 1'b1;
        end else begin
          mis   = i_is_mem_access && misal(i_alu_result, i_size);
          store = i_is_mem_access && i_mem_action;
          e_mis = mis;
          if (i_is_mem_access && !mis && !i_cache_valid) begin
            n_pend = 1'b1; n_resolved = 1'b0; n_data = i_alu_result; n_store = store;
            n_sign = i_sign_ext; n_size = i_size; n_rd = i_rw_addr;
            n_uses = i_uses_rw && !store;
          end else begin
            present((i_is_mem_access && !mis && !store) ?
                    load_val(i_cache_data, i_alu_result, i_size, i_sign_ext) : i_alu_result,
                    i_uses_rw && !store && !mis, i_rw_addr);
          end
        end
      end else if (!m_resolved) begin
        if (i_cache_valid)
          present(m_store ? m_data : load_val(i_cache_data, m_data, m_size, m_sign), m_uses, m_rd);
      end else begin
        present(m_data, m_uses, m_rd);
      end
      n_waits = (waiting && n_pend && !n_resolved) ? m_waits + 1 : 0;
      chk("done", 32'(o_done), 32'(e_done));
      chk("wb_valid", 32'(o_wb_valid), 32'(e_valid));
      chk("misaligned", 32'(o_misaligned), 32'(e_mis));
      chk("timeout", 32'(o_timeout), 32'(e_to));
      if (e_valid) begin
        chk("wb_uses_rw", 32'(o_wb_uses_rw), 32'(e_uses));
        chk("wb_rw_addr", 32'(o_wb_rw_addr), 32'(e_rd));
        chk("wb_rw_data", o_wb_rw_data, e_data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    i_valid = 0; i_flush = 0; i_is_mem_access = 0; i_mem_action = 0; i_size = 2'd0;
    i_sign_ext = 0; i_alu_result = 32'd0; i_uses_rw = 0; i_rw_addr = 5'd0;
    i_cache_valid = 0; i_cache_data = 32'd0; i_wb_ready = 1;
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic [1:0] sz, input logic sx,
                        input logic wr, input logic [4:0] rd);
    i_valid = 1; i_is_mem_access = 1; i_mem_action = wr; i_alu_result = addr; i_size = sz;
    i_sign_ext = sx; i_uses_rw = 1; i_rw_addr = rd; i_cache_valid = 0; i_wb_ready = 1;
  endtask

  task automatic check_reset_values;
    chk("rst_done", 32'(o_done), 32'd1);
    chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("rst_uses_rw", 32'(o_wb_uses_rw), 32'd0);
    chk("rst_rw_addr", 32'(o_wb_rw_addr), 32'd0);
    chk("rst_rw_data", o_wb_rw_data, 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
  endtask

  initial begin
    clear_in();
    #2 check_reset_values();
    tick(); tick();
    rst = 0;

    // Non-memory instruction completes in the same cycle.
    i_valid = 1; i_alu_result = 32'h1234; i_uses_rw = 1; i_rw_addr = 5'd7;
    @(negedge clk);
    chk("alu_done", 32'(o_done), 32'd1);
    chk("alu_data", o_wb_rw_data, 32'h1234);
    chk("alu_rd", 32'(o_wb_rw_addr), 32'd7);
    tick(); clear_in();

    // lb miss, five stalled cycles, then sign-extended byte from lane 2.
    mem_op(32'h1002, 2'd0, 1'b1, 1'b0, 5'd3);
    repeat (5) begin
      @(negedge clk); chk("lb_stall", 32'(o_done), 32'd0); tick();
    end
    i_cache_valid = 1; i_cache_data = 32'h0080_0000;
    @(negedge clk);
    chk("lb_done", 32'(o_done), 32'd1);
    chk("lb_data", o_wb_rw_data, 32'hFFFF_FF80);
    tick(); clear_in();

    mem_op(32'h1002, 2'd0, 1'b0, 1'b0, 5'd4);
    repeat (2) tick();
    i_cache_valid = 1; i_cache_data = 32'h0080_0000;
    @(negedge clk);
    chk("lbu_data", o_wb_rw_data, 32'h0000_0080);
    tick(); clear_in();

    // lhu hit while write-back stalls; cache data changes underneath the held result.
    mem_op(32'h2, 2'd1, 1'b0, 1'b0, 5'd5);
    i_cache_valid = 1; i_cache_data = 32'hBEEF_0000; i_wb_ready = 0;
    @(negedge clk); chk("lhu_stall0", 32'(o_done), 32'd0);
    tick(); i_cache_data = 32'd0; i_cache_valid = 0;
    repeat (2) begin
      @(negedge clk); chk("lhu_stall", 32'(o_done), 32'd0); tick();
    end
    i_wb_ready = 1;
    @(negedge clk);
    chk("lhu_done", 32'(o_done), 32'd1);
    chk("lhu_data", o_wb_rw_data, 32'h0000_BEEF);
    tick(); clear_in();

    // Misaligned lw: immediate completion, no register write.
    mem_op(32'h1001, 2'd2, 1'b0, 1'b0, 5'd6);
    @(negedge clk);
    chk("mis_pulse", 32'(o_misaligned), 32'd1);
    chk("mis_uses", 32'(o_wb_uses_rw), 32'd0);
    chk("mis_done", 32'(o_done), 32'd1);
    tick(); clear_in();
    @(negedge clk); chk("mis_clear", 32'(o_misaligned), 32'd0);
    tick();

    // Store hit forwards the ALU result without a register write.
    mem_op(32'h3000, 2'd2, 1'b0, 1'b1, 5'd9);
    i_cache_valid = 1;
    @(negedge clk);
    chk("st_uses", 32'(o_wb_uses_rw), 32'd0);
    chk("st_data", o_wb_rw_data, 32'h3000);
    tick(); clear_in();

    // Flush in WAIT beats a simultaneous cache response.
    mem_op(32'h2000, 2'd2, 1'b0, 1'b0, 5'd8);
    tick(); tick();
    i_flush = 1; i_cache_valid = 1; i_cache_data = 32'h5555;
    @(negedge clk);
    chk("flush_done", 32'(o_done), 32'd1);
    chk("flush_valid", 32'(o_wb_valid), 32'd0);
    tick(); clear_in();
    i_valid = 1; i_alu_result = 32'hABCD; i_rw_addr = 5'd2;
    @(negedge clk); chk("post_flush_idle", 32'(o_wb_valid), 32'd1);
    tick(); clear_in();

    // Asynchronous reset while holding a stalled result.
    i_valid = 1; i_alu_result = 32'h77; i_rw_addr = 5'd1; i_uses_rw = 1; i_wb_ready = 0;
    tick();
    #1 rst = 1; clear_in();
    #1 check_reset_values();
    #1 rst = 0;
    tick();

    // Cache silent for six WAIT cycles.
    mem_op(32'h40, 2'd2, 1'b0, 1'b0, 5'd10);
    repeat (7) tick();
    i_cache_valid = 1; i_cache_data = 32'h1234_5678;
    @(negedge clk);
    chk("to_data", o_wb_rw_data, 32'h1234_5678);
    tick(); clear_in();
    @(negedge clk); chk("to_sticky", 32'(o_timeout), 32'(ToEn));
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
